// File: rtl/risk_v_pkg.sv
// Shared encodings for the core run controller.
// Run states, halt causes and the EBREAK default.
package risk_v_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_HALTED = 3'd3,
    S_STEP   = 3'd4
  } run_state_t;

  typedef enum logic [1:0] {
    HC_NONE   = 2'b00,
    HC_EBREAK = 2'b01,
    HC_BP     = 2'b10,
    HC_CMD    = 2'b11
  } halt_cause_t;

  localparam logic [31:0] HALT_INSTR_DEF = 32'h00100073;

endpackage

// File: rtl/ld_byte_packer.sv
// Byte-to-word assembler for program load: LSB-first packing,
// word pointer, write strobe, overflow flag and load-done pulse.
module ld_byte_packer #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          err_overflow,
  output logic          done
);

  logic [AW:0]  ptr;
  logic [1:0]   bcnt;
  logic [23:0]  acc;
  logic [31:0]  merged;
  logic         full;
  logic         take;

  // ptr stops at DEPTH, so its MSB alone marks a full memory
  assign full = ptr[AW];
  assign take = en && ld_valid;

  // acc holds only the bytes seen so far, so upper bytes stay zero
  always_comb begin
    merged = {8'h00, acc}
           | ({24'h0, ld_data} << {bcnt, 3'b000});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr          <= '0;
      bcnt         <= '0;
      acc          <= '0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      err_overflow <= 1'b0;
      done         <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      if (clr) begin
        ptr          <= '0;
        bcnt         <= '0;
        acc          <= '0;
        err_overflow <= 1'b0;
      end else if (take) begin
        if (full) begin
          err_overflow <= 1'b1;
        end else if (bcnt == 2'd3 || ld_last) begin
          imem_we    <= 1'b1;
          imem_waddr <= ptr[AW-1:0];
          imem_wdata <= merged;
          ptr        <= ptr + 1'b1;
          bcnt       <= '0;
          acc        <= '0;
        end else begin
          acc  <= merged[23:0];
          bcnt <= bcnt + 2'd1;
        end
        if (ld_last) begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller: program load, run/halt/step FSM, commit gating,
// breakpoint/EBREAK halt, retired-instruction counter.
module core_run_ctrl
  import risk_v_pkg::*;
#(
  parameter int          IMEM_DEPTH = 64,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cmd_load,
  input  logic                          cmd_run,
  input  logic                          cmd_halt,
  input  logic                          cmd_step,
  input  logic                          ld_valid,
  input  logic [7:0]                    ld_data,
  input  logic                          ld_last,
  output logic                          ld_ready,
  input  logic [31:0]                   PC,
  input  logic [31:0]                   Instr,
  input  logic                          bp_en,
  input  logic [31:0]                   bp_addr,
  output logic                          core_rst_n,
  output logic                          commit_en,
  output logic                          imem_we,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  output logic [31:0]                   imem_wdata,
  output logic [2:0]                    state,
  output logic [1:0]                    halt_cause,
  output logic [CNT_W-1:0]              instret,
  output logic                          err_overflow
);

  run_state_t  state_q, state_d;
  halt_cause_t cause_q, cause_d;
  logic        mask_q, mask_d;
  logic        rst_q;
  logic [CNT_W-1:0] cnt_q;
  logic        commit;
  logic        ld_clr;
  logic        cnt_clr;
  logic        ld_done;
  logic        pk_en;
  logic        ebreak_hit;
  logic        bp_hit;
  logic        bp_live;

  assign ebreak_hit = (Instr == HALT_INSTR);
  assign bp_hit     = bp_en && (PC == bp_addr);
  assign bp_live    = bp_hit && !mask_q;

  // stop accepting once ld_last is in; the final write is in flight
  assign pk_en    = (state_q == S_LOAD) && !ld_done;
  assign ld_ready = pk_en;

  ld_byte_packer #(
    .DEPTH (IMEM_DEPTH)
  ) u_pack (
    .clk          (clk),
    .reset_n      (reset_n),
    .clr          (ld_clr),
    .en           (pk_en),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .err_overflow (err_overflow),
    .done         (ld_done)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    mask_d  = 1'b0;
    commit  = 1'b0;
    ld_clr  = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_run) begin
          state_d = S_RUN;
          cnt_clr = 1'b1;
        end else if (cmd_load) begin
          state_d = S_LOAD;
          ld_clr  = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      S_LOAD: begin
        if (ld_done) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        commit = !ebreak_hit && !bp_live && !cmd_halt;
        if (!commit) begin
          state_d = S_HALTED;
          if (ebreak_hit)   cause_d = HC_EBREAK;
          else if (bp_live) cause_d = HC_BP;
          else              cause_d = HC_CMD;
        end
      end
      S_HALTED: begin
        if (cmd_step) begin
          state_d = S_STEP;
          cause_d = HC_NONE;
        end else if (cmd_run) begin
          state_d = S_RUN;
          cause_d = HC_NONE;
          mask_d  = 1'b1;
        end else if (cmd_load) begin
          state_d = S_LOAD;
          cause_d = HC_NONE;
          ld_clr  = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      S_STEP: begin
        commit  = !ebreak_hit;
        state_d = S_HALTED;
        cause_d = ebreak_hit ? HC_EBREAK : HC_NONE;
      end
      default: begin
        state_d = S_IDLE;
        cause_d = HC_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cause_q <= HC_NONE;
      mask_q  <= 1'b0;
      rst_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      mask_q  <= mask_d;
      // release the core on the same edge it enters RUN
      rst_q   <= (state_d == S_RUN)
              || (state_d == S_HALTED)
              || (state_d == S_STEP);
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (commit && !(&cnt_q)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign commit_en  = commit;
  assign core_rst_n = rst_q;
  assign state      = state_q;
  assign halt_cause = cause_q;
  assign instret    = cnt_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl with a tiny core/IMEM model.
module tb_core_run_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_load = 0, cmd_run = 0;
  logic        cmd_halt = 0, cmd_step = 0;
  logic        ld_valid = 0, ld_last = 0;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_ready;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        bp_en = 0;
  logic [31:0] bp_addr = 32'h0;
  logic        core_rst_n, commit_en, imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [2:0]  state;
  logic [1:0]  halt_cause;
  logic [31:0] instret;
  logic        err_overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  logic [31:0] mem [64];
  logic [7:0]  bq [$];

  always #5 clk = ~clk;

  core_run_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_load     (cmd_load),
    .cmd_run      (cmd_run),
    .cmd_halt     (cmd_halt),
    .cmd_step     (cmd_step),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .PC           (pc),
    .Instr        (instr),
    .bp_en        (bp_en),
    .bp_addr      (bp_addr),
    .core_rst_n   (core_rst_n),
    .commit_en    (commit_en),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .state        (state),
    .halt_cause   (halt_cause),
    .instret      (instret),
    .err_overflow (err_overflow)
  );

  always @(posedge clk) begin
    if (imem_we) begin
      mem[imem_waddr] <= imem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (!core_rst_n) pc <= 32'h0;
    else if (commit_en) pc <= pc + 32'd4;
  end

  assign instr = mem[pc[7:2]];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int which);
    case (which)
      0: cmd_load = 1;
      1: cmd_run  = 1;
      2: cmd_halt = 1;
      default: cmd_step = 1;
    endcase
    cyc(1);
    cmd_load = 0; cmd_run = 0;
    cmd_halt = 0; cmd_step = 0;
  endtask

  task automatic put_word(input logic [31:0] w);
    bq.push_back(w[7:0]);
    bq.push_back(w[15:8]);
    bq.push_back(w[23:16]);
    bq.push_back(w[31:24]);
  endtask

  task automatic send(input bit with_last);
    int n;
    for (int i = 0; i < bq.size(); i++) begin
      ld_valid = 1;
      ld_data  = bq[i];
      ld_last  = with_last && (i == bq.size() - 1);
      n = 0;
      while (!ld_ready && n < 20) begin
        cyc(1);
        n++;
      end
      if (n == 20) check("ld_ready timeout", 0, 1);
      cyc(1);
    end
    ld_valid = 0;
    ld_last  = 0;
    bq.delete();
  endtask

  task automatic wait_halt();
    int n = 0;
    while (state !== 3'd3 && n < 200) begin
      cyc(1);
      n++;
    end
    check("halt reached", state, 3);
  endtask

  int base;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    #23;
    check("rst state", state, 0);
    check("rst core_rst_n", core_rst_n, 0);
    check("rst ld_ready", ld_ready, 0);
    check("rst instret", instret, 0);
    reset_n = 1;
    cyc(2);

    // partial final word: upper byte lanes zero
    base = wr_cnt;
    pulse(0);
    check("load state", state, 1);
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send(1);
    cyc(2);
    check("t2 writes", wr_cnt - base, 2);
    check("t2 addr0", mem[0], 32'hDDCCBBAA);
    check("t2 addr1", mem[1], 32'h000000EE);
    check("t2 idle", state, 0);

    base = wr_cnt;
    pulse(0);
    bq = '{8'h13, 8'h05, 8'h50, 8'h00,
           8'h73, 8'h00, 8'h10, 8'h00};
    send(1);
    cyc(2);
    check("t1 writes", wr_cnt - base, 2);
    check("t1 addr0", mem[0], 32'h00500513);
    check("t1 addr1", mem[1], 32'h00100073);
    check("t1 idle", state, 0);
    check("t1 core_rst_n", core_rst_n, 0);

    // run into EBREAK at PC=4
    pulse(1);
    check("t3 run", state, 2);
    check("t3 core_rst_n", core_rst_n, 1);
    @(negedge clk);
    check("t3 commit pc0", commit_en, 1);
    cyc(1);
    @(negedge clk);
    check("t3 pc", pc, 4);
    check("t3 instret", instret, 1);
    check("t3 no commit", commit_en, 0);
    cyc(1);
    check("t3 halted", state, 3);
    check("t3 cause", halt_cause, 1);
    check("t3 instret hold", instret, 1);
    cyc(3);
    check("t3 pc frozen", pc, 4);

    // reload from HALTED: 16 NOPs then EBREAK
    pulse(0);
    check("t4 load", state, 1);
    check("t4 core_rst_n", core_rst_n, 0);
    check("t4 cause clr", halt_cause, 0);
    for (int i = 0; i < 16; i++) put_word(32'h00000013);
    put_word(32'h00100073);
    send(1);
    cyc(2);
    bp_en = 1;
    bp_addr = 32'h8;
    pulse(1);
    wait_halt();
    check("t4 bp pc", pc, 8);
    check("t4 bp cause", halt_cause, 2);
    check("t4 instret", instret, 2);
    pulse(1);
    check("t4 resume", state, 2);
    check("t4 cause left", halt_cause, 0);
    @(negedge clk);
    check("t4 masked commit", commit_en, 1);
    cyc(1);
    @(negedge clk);
    check("t4 pc12", pc, 12);
    check("t4 still run", state, 2);

    // halt+run together in RUN: halt wins
    cyc(1);
    cmd_halt = 1;
    cmd_run  = 1;
    @(negedge clk);
    check("t5 halt no commit", commit_en, 0);
    cyc(1);
    cmd_halt = 0;
    cmd_run  = 0;
    check("t5 halted", state, 3);
    check("t5 cause", halt_cause, 3);
    check("t5 pc", pc, 16);
    check("t5 instret", instret, 4);
    for (int i = 0; i < 3; i++) begin
      pulse(3);
      check("t5 step state", state, 4);
      cyc(1);
      check("t5 back halted", state, 3);
    end
    check("t5 step pc", pc, 28);
    check("t5 step instret", instret, 7);
    check("t5 step cause", halt_cause, 0);

    bp_en = 0;
    pulse(1);
    wait_halt();
    check("t5 ebreak pc", pc, 64);
    check("t5 ebreak cause", halt_cause, 1);
    check("t5 ebreak instret", instret, 16);

    // stepping onto EBREAK does not commit
    pulse(3);
    @(negedge clk);
    check("t5 step eb commit", commit_en, 0);
    cyc(1);
    check("t5 step eb cause", halt_cause, 1);
    check("t5 step eb instret", instret, 16);

    // overflow: 64 words plus one extra word
    base = wr_cnt;
    pulse(0);
    for (int i = 0; i < 65; i++) put_word(i);
    send(1);
    cyc(2);
    check("t6 writes", wr_cnt - base, 64);
    check("t6 overflow", err_overflow, 1);
    check("t6 idle", state, 0);
    check("t6 last word", mem[63], 63);

    // reset mid-load discards the partial word
    pulse(0);
    check("t6 ovf cleared", err_overflow, 0);
    bq = '{8'h11, 8'h22};
    send(0);
    @(negedge clk);
    reset_n = 0;
    #2;
    check("arst state", state, 0);
    check("arst ld_ready", ld_ready, 0);
    check("arst core_rst_n", core_rst_n, 0);
    check("arst commit", commit_en, 0);
    check("arst we", imem_we, 0);
    check("arst cause", halt_cause, 0);
    check("arst ovf", err_overflow, 0);
    cyc(1);
    reset_n = 1;
    cyc(1);
    base = wr_cnt;
    pulse(0);
    bq = '{8'h55};
    send(1);
    cyc(2);
    check("arst writes", wr_cnt - base, 1);
    check("arst fresh word", mem[0], 32'h00000055);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
